multicycle_control_unit: RTL and testbench

- Finite-state control unit for the next-generation multi-cycle RV32I core.
- Replaces the single-cycle decode/control path with a shared ALU and a single unified instruction/data memory port.
- Adds a variable-latency memory handshake (mem_req/mem_ready), halt detection, and parametrised performance counters.
- Drives the enables and mux selects of the multi-cycle datapath: PC, IR, MDR, ALUOut, register file and memory.

---
 rtl/multicycle_control_unit.sv | 199 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control unit: sequences fetch, decode, execute, memory and
// writeback over a shared ALU and a single unified memory port with a
// variable-latency request/ready handshake. Also tracks cycle and retired
// instruction counts and stops in an absorbing HALT on the halt ECALL.
module multicycle_control_unit #(
   parameter int XLEN      = 32,
   parameter int CNT_WIDTH = 32,
   parameter int HALT_CODE = 10
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [6:0]           opcode,
   input  logic                 alu_bcond,
   input  logic [XLEN-1:0]      gpr_x17,
   input  logic                 mem_ready,
   output logic                 mem_req,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic                 i_or_d,
   output logic                 ir_write,
   output logic                 mdr_write,
   output logic                 aluout_write,
   output logic                 reg_write,
   output logic                 pc_write,
   output logic [1:0]           pc_source,
   output logic                 alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [1:0]           alu_op_sel,
   output logic [1:0]           wb_sel,
   output logic [2:0]           state,
   output logic                 is_halted,
   output logic [CNT_WIDTH-1:0] cycle_count,
   output logic [CNT_WIDTH-1:0] instret_count
);

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_ECALL  = 7'b1110011;

   localparam logic [XLEN-1:0] HALT_VAL = XLEN'(HALT_CODE);

   state_t                 state_reg, state_next;
   logic [CNT_WIDTH-1:0]   cycle_reg;
   logic [CNT_WIDTH-1:0]   instret_reg;
   logic                   halt_call;
   logic                   enter_halt;

   assign halt_call  = (opcode == OP_ECALL) && (gpr_x17 == HALT_VAL);
   assign enter_halt = reset && (state_reg == S_EX) && halt_call;

   assign state         = state_reg;
   assign cycle_count   = cycle_reg;
   assign instret_count = instret_reg;

   // Control decode and next state; everything is held at 0 while reset is low
   // so an in-flight memory request drops without waiting for a clock edge.
   always_comb begin
      mem_req      = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      i_or_d       = 1'b0;
      ir_write     = 1'b0;
      mdr_write    = 1'b0;
      aluout_write = 1'b0;
      reg_write    = 1'b0;
      pc_write     = 1'b0;
      pc_source    = 2'b00;
      alu_src_a    = 1'b0;
      alu_src_b    = 2'b00;
      alu_op_sel   = 2'b00;
      wb_sel       = 2'b00;
      is_halted    = 1'b0;
      state_next   = state_reg;
      if (reset) begin
         case (state_reg)
            S_IF: begin
               mem_req  = 1'b1;
               mem_read = 1'b1;
               if (mem_ready) begin
                  ir_write   = 1'b1;
                  state_next = S_ID;
               end
            end
            S_ID: begin
               // Speculative branch/JAL target: ALUOut <= PC + imm
               alu_src_b    = 2'b01;
               aluout_write = 1'b1;
               state_next   = S_EX;
            end
            S_EX: begin
               state_next = S_IF;
               case (opcode)
                  OP_R, OP_I: begin
                     alu_src_a    = 1'b1;
                     alu_src_b    = (opcode == OP_I) ? 2'b01 : 2'b00;
                     alu_op_sel   = 2'b10;
                     aluout_write = 1'b1;
                     state_next   = S_WB;
                  end
                  OP_LOAD, OP_STORE: begin
                     alu_src_a    = 1'b1;
                     alu_src_b    = 2'b01;
                     aluout_write = 1'b1;
                     state_next   = S_MEM;
                  end
                  OP_BRANCH: begin
                     alu_src_a  = 1'b1;
                     alu_op_sel = 2'b01;
                     pc_write   = 1'b1;
                     pc_source  = alu_bcond ? 2'b01 : 2'b00;
                  end
                  OP_JAL: begin
                     reg_write = 1'b1;
                     wb_sel    = 2'b10;
                     pc_write  = 1'b1;
                     pc_source = 2'b01;
                  end
                  OP_JALR: begin
                     alu_src_a = 1'b1;
                     alu_src_b = 2'b01;
                     reg_write = 1'b1;
                     wb_sel    = 2'b10;
                     pc_write  = 1'b1;
                     pc_source = 2'b10;
                  end
                  OP_ECALL: begin
                     if (halt_call) begin
                        state_next = S_HALT;
                     end else begin
                        pc_write = 1'b1;
                     end
                  end
                  default: pc_write = 1'b1;
               endcase
            end
            S_MEM: begin
               mem_req = 1'b1;
               i_or_d  = 1'b1;
               if (opcode == OP_LOAD) begin
                  mem_read = 1'b1;
                  if (mem_ready) begin
                     mdr_write  = 1'b1;
                     state_next = S_WB;
                  end
               end else begin
                  mem_write = 1'b1;
                  if (mem_ready) begin
                     pc_write   = 1'b1;
                     state_next = S_IF;
                  end
               end
            end
            S_WB: begin
               reg_write  = 1'b1;
               wb_sel     = (opcode == OP_LOAD) ? 2'b01 : 2'b00;
               pc_write   = 1'b1;
               state_next = S_IF;
            end
            S_HALT: begin
               is_halted  = 1'b1;
               state_next = S_HALT;
            end
            default: state_next = S_IF;
         endcase
      end
   end

   // State register and wrapping performance counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= S_IF;
         cycle_reg   <= '0;
         instret_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg != S_HALT) begin
            cycle_reg <= cycle_reg + CNT_WIDTH'(1);
         end
         if (pc_write || enter_halt) begin
            instret_reg <= instret_reg + CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit. Each instruction is modelled
// as a list of phases (fetch with waits, decode, execute, optional memory with
// waits, optional writeback) with the expected control vector of each phase;
// counters are modelled per instruction as "cycles taken" and "one retired".
// A second instance with 4-bit counters checks wrap-around.
module tb_multicycle_control_unit;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_ECALL  = 7'b1110011;

   localparam int PH_IF   = 0;
   localparam int PH_ID   = 1;
   localparam int PH_EX   = 2;
   localparam int PH_MEM  = 3;
   localparam int PH_WB   = 4;
   localparam int PH_HALT = 5;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [6:0]  opcode = 7'd0;
   logic        alu_bcond = 1'b0;
   logic [31:0] gpr_x17 = 32'd0;
   logic        mem_ready = 1'b0;

   logic        mem_req, mem_read, mem_write, i_or_d, ir_write, mdr_write;
   logic        aluout_write, reg_write, pc_write, alu_src_a, is_halted;
   logic [1:0]  pc_source, alu_src_b, alu_op_sel, wb_sel;
   logic [2:0]  state;
   logic [31:0] cycle_count, instret_count;

   logic        w_mem_req, w_mem_read, w_mem_write, w_i_or_d, w_ir_write, w_mdr_write;
   logic        w_aluout_write, w_reg_write, w_pc_write, w_alu_src_a, w_is_halted;
   logic [1:0]  w_pc_source, w_alu_src_b, w_alu_op_sel, w_wb_sel;
   logic [2:0]  w_state;
   logic [3:0]  w_cycle_count, w_instret_count;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] cyc_m = 32'd0;
   logic [31:0] ins_m = 32'd0;
   logic        halted_m = 1'b0;

   always #5 clk = ~clk;

   multicycle_control_unit dut (
      .clk(clk), .reset(reset), .opcode(opcode), .alu_bcond(alu_bcond),
      .gpr_x17(gpr_x17), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write),
      .i_or_d(i_or_d), .ir_write(ir_write), .mdr_write(mdr_write),
      .aluout_write(aluout_write), .reg_write(reg_write), .pc_write(pc_write),
      .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op_sel(alu_op_sel), .wb_sel(wb_sel), .state(state),
      .is_halted(is_halted), .cycle_count(cycle_count),
      .instret_count(instret_count)
   );

   multicycle_control_unit #(.CNT_WIDTH(4)) dut4 (
      .clk(clk), .reset(reset), .opcode(opcode), .alu_bcond(alu_bcond),
      .gpr_x17(gpr_x17), .mem_ready(mem_ready),
      .mem_req(w_mem_req), .mem_read(w_mem_read), .mem_write(w_mem_write),
      .i_or_d(w_i_or_d), .ir_write(w_ir_write), .mdr_write(w_mdr_write),
      .aluout_write(w_aluout_write), .reg_write(w_reg_write), .pc_write(w_pc_write),
      .pc_source(w_pc_source), .alu_src_a(w_alu_src_a), .alu_src_b(w_alu_src_b),
      .alu_op_sel(w_alu_op_sel), .wb_sel(w_wb_sel), .state(w_state),
      .is_halted(w_is_halted), .cycle_count(w_cycle_count),
      .instret_count(w_instret_count)
   );

   wire [18:0] got_ctrl = {mem_req, mem_read, mem_write, i_or_d, ir_write, mdr_write,
                           aluout_write, reg_write, pc_write, pc_source, alu_src_a,
                           alu_src_b, alu_op_sel, wb_sel, is_halted};

   // Expected control vector for one phase of an instruction
   function automatic logic [18:0] exp_ctrl(int ph, logic [6:0] op, logic bc,
                                            logic halt_call, logic rdy);
      logic req, rd, wr, iod, irw, mdrw, aow, rw, pcw, asa, hlt;
      logic [1:0] pcs, asb, aop, wbs;
      {req, rd, wr, iod, irw, mdrw, aow, rw, pcw, asa, hlt} = '0;
      {pcs, asb, aop, wbs} = '0;
      case (ph)
         PH_IF: begin req = 1; rd = 1; irw = rdy; end
         PH_ID: begin asb = 2'b01; aow = 1; end
         PH_EX: begin
            if (op == OP_R)         begin asa = 1; aop = 2'b10; aow = 1; end
            else if (op == OP_I)    begin asa = 1; asb = 2'b01; aop = 2'b10; aow = 1; end
            else if (op == OP_LOAD || op == OP_STORE)
                                    begin asa = 1; asb = 2'b01; aow = 1; end
            else if (op == OP_BRANCH) begin asa = 1; aop = 2'b01; pcw = 1; pcs = bc ? 2'b01 : 2'b00; end
            else if (op == OP_JAL)  begin rw = 1; wbs = 2'b10; pcw = 1; pcs = 2'b01; end
            else if (op == OP_JALR) begin asa = 1; asb = 2'b01; rw = 1; wbs = 2'b10; pcw = 1; pcs = 2'b10; end
            else if (op == OP_ECALL) pcw = !halt_call;
            else                    pcw = 1;
         end
         PH_MEM: begin
            req = 1; iod = 1;
            if (op == OP_LOAD) begin rd = 1; mdrw = rdy; end
            else begin wr = 1; pcw = rdy; end
         end
         PH_WB: begin rw = 1; wbs = (op == OP_LOAD) ? 2'b01 : 2'b00; pcw = 1; end
         PH_HALT: hlt = 1;
         default: ;
      endcase
      return {req, rd, wr, iod, irw, mdrw, aow, rw, pcw, pcs, asa, asb, aop, wbs, hlt};
   endfunction

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_counters(string tag);
      chk({tag, "_cycle"}, cycle_count, cyc_m);
      chk({tag, "_instret"}, instret_count, ins_m);
      chk({tag, "_cycle4"}, 32'(w_cycle_count), 32'(cyc_m[3:0]));
      chk({tag, "_instret4"}, 32'(w_instret_count), 32'(ins_m[3:0]));
   endtask

   // One clock cycle in a given phase: drive, check at negedge, advance
   task automatic step(string tag, int ph, logic [6:0] op, logic bc, logic rdy);
      opcode    = (ph == PH_IF || ph == PH_HALT) ? 7'($urandom) : op;
      alu_bcond = (ph == PH_EX) ? bc : 1'($urandom);
      mem_ready = rdy;
      @(negedge clk);
      chk($sformatf("%s_ph%0d_ctrl", tag, ph), 32'(got_ctrl),
          32'(exp_ctrl(ph, op, bc, gpr_x17 == 32'd10, rdy)));
      chk($sformatf("%s_ph%0d_state", tag, ph), 32'(state), ph);
      @(posedge clk);
      #1;
   endtask

   task automatic run_instr(string tag, logic [6:0] op, logic bc, logic [31:0] x17,
                            int wif, int wm);
      int n;
      logic halt;
      gpr_x17 = x17;
      halt = (op == OP_ECALL) && (x17 == 32'd10);
      for (int k = 0; k <= wif; k++) step(tag, PH_IF, op, bc, k == wif);
      step(tag, PH_ID, op, bc, 1'($urandom));
      step(tag, PH_EX, op, bc, 1'($urandom));
      n = wif + 3;
      if (op == OP_LOAD || op == OP_STORE) begin
         for (int k = 0; k <= wm; k++) step(tag, PH_MEM, op, bc, k == wm);
         n += wm + 1;
      end
      if (op == OP_LOAD || op == OP_R || op == OP_I) begin
         step(tag, PH_WB, op, bc, 1'($urandom));
         n += 1;
      end
      cyc_m += 32'(n);
      ins_m += 1;
      halted_m = halt;
      $display("instr %s op=%b bc=%0d x17=%0d wif=%0d wm=%0d cycles=%0d cyc=%0d ins=%0d",
               tag, op, bc, x17, wif, wm, n, cycle_count, instret_count);
      chk_counters(tag);
      chk({tag, "_end_state"}, 32'(state), halt ? PH_HALT : PH_IF);
   endtask

   task automatic halt_hold(int n);
      for (int k = 0; k < n; k++) step("halt", PH_HALT, 7'd0, 1'b0, 1'($urandom));
      $display("halt hold %0d cycles cyc=%0d ins=%0d", n, cycle_count, instret_count);
      chk_counters("halt_frozen");
   endtask

   task automatic do_reset(int cycles);
      reset = 1'b0;
      mem_ready = 1'b1;
      #1;
      cyc_m = 0;
      ins_m = 0;
      halted_m = 1'b0;
      chk("rst_ctrl", 32'(got_ctrl), 32'd0);
      chk("rst_state", 32'(state), PH_IF);
      chk_counters("rst");
      repeat (cycles) @(posedge clk);
      #1;
      chk("rst_hold_ctrl", 32'(got_ctrl), 32'd0);
      chk_counters("rst_hold");
      reset = 1'b1;
      $display("reset released after %0d cycles", cycles);
   endtask

   logic [6:0] rop;
   int         sel;

   initial begin
      // Reset, then a plain ADDI: 4 cycles, 1 retired
      do_reset(3);
      run_instr("addi", OP_I, 1'b0, 32'd0, 0, 0);
      chk("addi_cycle4_exact", cycle_count, 32'd4);
      // LW with three wait cycles in MEM: 8 cycles total
      do_reset(1);
      run_instr("lw_wait3", OP_LOAD, 1'b0, 32'd0, 0, 3);
      chk("lw_cycle8_exact", cycle_count, 32'd8);
      // Branches taken and not taken, store, jumps, R-type, non-halt ECALL, NOP
      run_instr("beq_t", OP_BRANCH, 1'b1, 32'd0, 0, 0);
      run_instr("beq_nt", OP_BRANCH, 1'b0, 32'd0, 1, 0);
      run_instr("sw", OP_STORE, 1'b0, 32'd0, 2, 2);
      run_instr("jal", OP_JAL, 1'b0, 32'd0, 0, 0);
      run_instr("jalr", OP_JALR, 1'b1, 32'd0, 0, 0);
      run_instr("add", OP_R, 1'b0, 32'd0, 0, 0);
      run_instr("ecall5", OP_ECALL, 1'b0, 32'd5, 0, 0);
      run_instr("nop", 7'b0001111, 1'b0, 32'd10, 0, 0);
      // Halting ECALL from reset: frozen at 3 cycles, 1 retired
      do_reset(1);
      run_instr("ecall10", OP_ECALL, 1'b0, 32'd10, 0, 0);
      chk("halt_cycle3_exact", cycle_count, 32'd3);
      halt_hold(4);
      // Wrap of the 4-bit counters: 6 ADDI = 24 cycles -> 8
      do_reset(1);
      for (int i = 0; i < 6; i++) run_instr("wrap_addi", OP_I, 1'b0, 32'd0, 0, 0);
      chk("wrap_cycle4_exact", 32'(w_cycle_count), 32'd8);
      chk("wrap_instret4_exact", 32'(w_instret_count), 32'd6);
      // Asynchronous reset in the middle of a memory access
      run_instr("pre", OP_I, 1'b0, 32'd0, 0, 0);
      step("lw_abort", PH_IF, OP_LOAD, 1'b0, 1'b1);
      step("lw_abort", PH_ID, OP_LOAD, 1'b0, 1'b0);
      step("lw_abort", PH_EX, OP_LOAD, 1'b0, 1'b0);
      opcode = OP_LOAD;
      mem_ready = 1'b0;
      #1;
      chk("mid_mem_req_before", 32'(mem_req), 32'd1);
      reset = 1'b0;
      #1;
      chk("mid_mem_req_dropped", 32'(mem_req), 32'd0);
      chk("mid_mem_state", 32'(state), PH_IF);
      chk("mid_mem_cycle", cycle_count, 32'd0);
      $display("async reset during MEM: mem_req=%0d state=%0d", mem_req, state);
      @(posedge clk);
      #1;
      reset = 1'b1;
      cyc_m = 0;
      ins_m = 0;
      // Asynchronous reset in the middle of a fetch
      mem_ready = 1'b0;
      #1;
      chk("mid_if_req_before", 32'(mem_req), 32'd1);
      reset = 1'b0;
      #1;
      chk("mid_if_req_dropped", 32'(mem_req), 32'd0);
      $display("async reset during IF: mem_req=%0d state=%0d", mem_req, state);
      @(posedge clk);
      #1;
      reset = 1'b1;
      // Randomized instruction stream
      for (int i = 0; i < 120; i++) begin
         sel = $urandom_range(0, 8);
         case (sel)
            0: rop = OP_R;
            1: rop = OP_I;
            2: rop = OP_LOAD;
            3: rop = OP_STORE;
            4: rop = OP_BRANCH;
            5: rop = OP_JAL;
            6: rop = OP_JALR;
            7: rop = OP_ECALL;
            default: rop = 7'($urandom);
         endcase
         run_instr($sformatf("rnd%0d", i), rop, 1'($urandom),
                   (rop == OP_ECALL) ? 32'($urandom_range(5, 12)) : $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3));
         if (halted_m) begin
            halt_hold(2);
            do_reset(1);
         end
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
